// File: rtl/video_stream_pkg.sv
// video_stream_pkg: shared types, defaults and colour expansion for the frame
// streaming path.
package video_stream_pkg;

   localparam int DEF_H_PIXELS = 640;
   localparam int DEF_V_LINES  = 480;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   typedef enum logic [1:0] {
      GRAY  = 2'b00,
      RED   = 2'b01,
      GREEN = 2'b10,
      BLUE  = 2'b11
   } color_mode_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic rgb_t map_color(input color_mode_t m, input logic [7:0] d);
      return '{r: (m == GRAY || m == RED)   ? d : 8'h00,
               g: (m == GRAY || m == GREEN) ? d : 8'h00,
               b: (m == GRAY || m == BLUE)  ? d : 8'h00};
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word fall-through FIFO with occupancy count; a push and
// a pop on a full FIFO in the same cycle are legal.
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 26,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   assign do_pop = pop_i && count_q != '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
         count_q <= count_q + CW'(push_i) - CW'(do_pop);
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign valid_o = count_q != '0;
   assign count_o = count_q;

endmodule

// File: rtl/frame_stream_source.sv
// frame_stream_source: raster-scans the frame buffer and emits one Avalon-ST
// packet per frame of colour-expanded 24-bit pixels, honouring backpressure.
module frame_stream_source
   import video_stream_pkg::*;
#(
   parameter int H_PIXELS    = DEF_H_PIXELS,
   parameter int V_LINES     = DEF_V_LINES,
   parameter int ADDR_W      = 19,
   parameter int MEM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        color_selector,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [7:0]        mem_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [23:0]       out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_empty,
   output logic              frame_done
);

   localparam int XW = H_PIXELS > 1 ? $clog2(H_PIXELS) : 1;
   localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t            state_q;
   color_mode_t       mode_q;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        tag_q [MEM_LATENCY];
   logic              frame_done_q;

   logic [CW-1:0] fifo_count, inflight;
   logic [25:0]   head;
   logic [2:0]    tag_last;
   rgb_t          pix;
   logic          last_x, last_y, last_px, issue, beat, eop_beat;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + CW'(tag_q[i][2]);
   end

   // Credit counts both buffered and in-flight samples, so the FIFO cannot overflow.
   assign issue    = state_q == STREAM &&
                     ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
   assign last_x   = x_q == XW'(H_PIXELS - 1);
   assign last_y   = y_q == YW'(V_LINES - 1);
   assign last_px  = last_x && last_y;
   assign beat     = out_valid && out_ready;
   assign eop_beat = beat && out_eop;
   assign tag_last = tag_q[MEM_LATENCY-1];
   assign pix      = map_color(mode_q, mem_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mode_q       <= GRAY;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         frame_done_q <= eop_beat;
         tag_q[0]     <= {issue, issue && addr_q == '0, issue && last_px};
         for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
         if (issue) begin
            x_q    <= last_x ? '0 : x_q + 1'b1;
            y_q    <= last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
            addr_q <= last_px ? '0 : addr_q + 1'b1;
         end
         case (state_q)
            IDLE: if (enable) begin
               state_q <= STREAM;
               mode_q  <= color_mode_t'(color_selector);
            end
            STREAM: if (issue && last_px) state_q <= DRAIN;
            DRAIN: if (eop_beat) begin
               state_q <= enable ? STREAM : IDLE;
               mode_q  <= color_mode_t'(color_selector);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (26),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (tag_last[2]),
      .din_i   ({tag_last[1], tag_last[0], pix}),
      .pop_i   (out_ready),
      .dout_o  (head),
      .valid_o (out_valid),
      .count_o (fifo_count)
   );

   assign mem_address = addr_q;
   assign out_data    = head[23:0];
   assign out_sop     = out_valid && head[25];
   assign out_eop     = out_valid && head[24];
   assign out_empty   = 1'b0;
   assign frame_done  = frame_done_q;

endmodule
